stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the team's fixed 4-bit 8:1 select muxes. It adds two selection modes: fixed select and round-robin arbitration. It also adds a single output register stage that sustains one transfer per cycle. It sits between multiple producer channels and a single consumer datapath.

## Interface
Parameters:
- WIDTH, 4, data bits per channel
- N, 8, number of input channels (N ≥ 2)
- SELW, $clog2(N), select/channel-index width (derived, not overridden)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset: one clock; reset is synchronous and active-high
- mode  input  1  0 = fixed select by s, 1 = round-robin among valid inputs
- s  input  SELW  channel select, used only when mode = 0
- in_data  input  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  WIDTH  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready
- out_ch  output  SELW  index of the channel that supplied out_data

## Operation
- Output register: out_data, out_valid, out_ch. A transfer happens when out_valid && out_ready.
- load_en = !out_valid || out_ready. The register accepts a new word when it is empty or being drained in the same cycle.
- Grant logic is combinational each cycle and produces gnt_valid and gnt (SELW bits):
  - mode 0: gnt = s; gnt_valid = (s < N) && in_valid[s]. If s ≥ N (N not a power of 2), nothing is granted.
  - mode 1: gnt = first i with in_valid[i] = 1, searching (ptr+1) mod N, (ptr+2) mod N, …, ptr. gnt_valid = |in_valid.
- in_ready[i] = load_en && gnt_valid && (gnt == i). At most one bit is set. in_ready does not depend on in_valid of other channels except through the grant.
- Accept (load_en && gnt_valid) sets out_data ← channel gnt data, out_ch ← gnt, out_valid ← 1.
- Drain without accept (out_valid && out_ready && !gnt_valid) sets out_valid ← 0. out_data and out_ch hold their values.
- Round-robin pointer ptr (SELW bits):
  - Updates to gnt only on an accept in mode 1.
  - Holds in mode 0 and whenever there is no accept.
  - Wraps at N-1 → 0 and never holds a value ≥ N.
- Mode or s changes take effect on the grant in the same cycle. The output register already loaded is not affected.
- Input data must be held stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset (rst = 1 at a rising edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = N-1, so channel 0 has first priority after reset.
- During reset, in_ready is forced to 0.
- Reset mid-operation discards any held word. No partial transfer is reported.
- Latency: one cycle from input accept to out_valid.
- Throughput: one word per cycle while out_ready = 1 and a grant exists.
- Output backpressure: out_ready = 0 with out_valid = 1 freezes out_data and out_ch, and all in_ready go low.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one with no bubble.
- Round-robin fairness: with all N inputs continuously valid and out_ready = 1, grants cycle 0, 1, …, N-1, 0. Each channel is granted exactly once every N cycles.
- No other state, and no combinational path from in_data to out_data.

## Test plan
- Reset and fixed mode: hold rst for 2 cycles, then release.
  - Check out_valid = 0, out_data = 0, out_ch = 0 during reset.
  - Set mode = 0, s = 5, in_valid = 8'hFF, channel i data = i.
  - Next cycle: out_valid = 1, out_data = 4'h5, out_ch = 5. Only in_ready[5] = 1 while out_ready = 1.
- Round-robin sweep: mode = 1, in_valid = 8'hFF, out_ready = 1 held for 10 cycles after reset.
  - out_ch sequence is 0, 1, 2, 3, 4, 5, 6, 7, 0, 1.
  - out_valid stays 1 with no bubbles.
- Sparse round-robin: mode = 1, in_valid = 8'b1000_0100.
  - out_ch alternates 2, 7, 2, 7.
  - Then drop channel 7: out_ch stays 2 every cycle.
- Backpressure: with a word from ch 3 held, drive out_ready = 0 for 3 cycles.
  - out_data and out_ch are stable, in_ready = 0.
  - Raise out_ready: the next channel after 3 is loaded in the same cycle the held word drains.
- Boundary: N = 6, mode = 0, s = 7.
  - No in_ready asserts and out_valid drops after the drain.
  - Switch to mode = 1 with in_valid = 6'b100000: out_ch = 5, and ptr wraps so the next grant search starts at 0.
- Reset mid-stream: assert rst while out_valid = 1 and in_valid = all ones.
  - Next cycle out_valid = 0, and the first post-reset grant is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with fixed-select or
// round-robin arbitration, feeding a single registered output stage.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    s,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  logic [WIDTH-1:0] r_outData;
  logic             r_outValid;
  logic [SELW-1:0]  r_outCh;
  logic [SELW-1:0]  r_ptr;

  logic             w_loadEn;
  logic             w_accept;
  logic             w_fixValid;
  logic             w_rrValid;
  logic             w_gntValid;
  logic [SELW-1:0]  w_rrGnt;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_gntData;

  assign w_loadEn = !r_outValid || out_ready;

  // An out-of-range select (s >= N) matches no channel and so grants nothing.
  always_comb begin
    w_fixValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i)) w_fixValid = in_valid[i];
    end
  end

  // Scan from the farthest candidate back to ptr+1 so the nearest valid one wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_rrGnt = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % N;
      if (in_valid[idx]) w_rrGnt = SELW'(idx);
    end
  end

  assign w_rrValid  = |in_valid;
  assign w_gnt      = mode ? w_rrGnt : s;
  assign w_gntValid = mode ? w_rrValid : w_fixValid;
  assign w_accept   = w_loadEn && w_gntValid;

  always_comb begin
    w_gntData = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SELW'(i)) w_gntData = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && w_accept && (w_gnt == SELW'(i));
    end
  end

  // Pointer resets to N-1 so channel 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_ptr      <= SELW'(N - 1);
    end else begin
      if (w_accept) begin
        r_outValid <= 1'b1;
        r_outData  <= w_gntData;
        r_outCh    <= w_gnt;
        if (mode) r_ptr <= w_gnt;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign out_ch    = r_outCh;

endmodule
